nios_system_wstart: RTL and testbench
=====================================

// Module: nios_system_wstart
// PURPOSE
// - Avalon-MM slave output PIO: the CPU-to-fabric counterpart of the wdone input PIO.
// - The Nios CPU writes a command/data byte that drives out_port into the fabric, e.g. the write-start request.
// - Adds a self-clearing pulse register, so a one-shot start strobe needs a single CPU write.
// - Readback is registered: data is valid one clock after the read address is presented.
// PARAMETERS
// - WIDTH         8    out_port width in bits; legal range 1..31
// - RESET_VALUE   0    value loaded into data_reg on reset
// - PULSE_CYCLES  4    pulse duration in clk cycles; legal minimum 1
// PORTS
// - clk        in   1      system clock; all logic on posedge
// - reset_n    in   1      asynchronous, active-low reset
// - address    in   3      register word address
// - chipselect in   1      slave select
// - write_n    in   1      active-low write strobe; a write is chipselect & ~write_n
// - writedata  in   32     write data; only bits [WIDTH-1:0] are used
// - readdata   out  32     registered read data
// - out_port   out  WIDTH  out_port = data_reg | pulse_mask
// BEHAVIOUR
// - Reset, asynchronous on reset_n low:
//   - data_reg <= RESET_VALUE, pulse_mask <= 0, pulse_cnt <= 0, readdata <= 0.
//   - out_port therefore equals RESET_VALUE during reset.
// - Register map, by address:
//   - 0 DATA: write sets data_reg <= writedata[WIDTH-1:0]; read returns data_reg, zero-extended.
//   - 2 PULSE: write sets pulse_mask <= pulse_mask | writedata[WIDTH-1:0] and reloads pulse_cnt <= PULSE_CYCLES.
//   - 2 PULSE read: {busy, zeros, pulse_mask}, where busy = (pulse_cnt != 0) and sits in bit 31.
//   - 4 OUTSET and 5 OUTCLR exist only with the macro (see CONFIGURATION).
//   - 1, 3, 6, 7: reads return 0; writes are ignored.
// - Write timing: out_port reflects a write at the same posedge the write is sampled. No wait states.
// - Read timing:
//   - readdata <= mux(address) on every posedge; chipselect is not required.
//   - Latency is 1 cycle; the value returned is the register state before that edge.
// - Pulse engine, two states: IDLE (pulse_cnt == 0) and ACTIVE (pulse_cnt != 0).
//   - IDLE -> ACTIVE on a PULSE write with a nonzero mask. A zero-mask write still reloads the counter, so busy goes high.
//   - ACTIVE: pulse_cnt decrements by 1 each cycle.
//   - When pulse_cnt == 1 with no PULSE write: pulse_cnt <= 0 and pulse_mask <= 0, returning to IDLE.
//   - Result: the mask bits are high for exactly PULSE_CYCLES cycles after the write edge.
// - Boundary conditions:
//   - PULSE write while ACTIVE: mask bits OR in and the counter restarts at PULSE_CYCLES. The write wins over a same-cycle expiry.
//   - DATA write while ACTIVE: data_reg updates and the pulse continues unaffected.
//   - A bit high in both data_reg and pulse_mask stays high after the pulse expires.
//   - Writedata bits above WIDTH-1 are ignored; readdata bits above WIDTH-1 read 0, except PULSE bit 31.
//   - Reset mid-pulse: the pulse aborts immediately and out_port = RESET_VALUE.
// - Counter width is $clog2(PULSE_CYCLES+1). The counter never wraps; it saturates at 0.
// CONFIGURATION
// - Macro WSTART_BITSET_EN.
// - When defined:
//   - Write to address 4 sets data_reg <= data_reg | writedata[WIDTH-1:0].
//   - Write to address 5 sets data_reg <= data_reg & ~writedata[WIDTH-1:0].
//   - Reads of addresses 4 and 5 return 0.
// - When undefined: addresses 4 and 5 behave as reserved (writes ignored, reads 0), and the set/clear logic is not built.
// TESTING
// - Reset: hold reset_n=0 with RESET_VALUE=8'h5A -> out_port=8'h5A, readdata=0; release -> values unchanged.
// - Write DATA 32'hFFFF_FF3C -> out_port=8'h3C next edge; read addr 0 -> readdata=32'h0000_003C one cycle later.
// - Write PULSE 8'h01 with data_reg=0 -> out_port[0]=1 for exactly 4 cycles; read addr 2 -> 32'h8000_0001 while ACTIVE, then 0.
// - PULSE 8'h01, then PULSE 8'h02 two cycles later -> mask=8'h03, bit0 high for 6 cycles total, bit1 high for 4.
// - Assert reset_n low in the 2nd pulse cycle -> out_port=RESET_VALUE immediately; after release, busy=0.
// - WSTART_BITSET_EN: data 8'hF0, then OUTSET 8'h0F -> 8'hFF, then OUTCLR 8'h81 -> 8'h7E. Without the macro, data stays 8'hF0.

Source files
------------

// File: rtl/nios_system_wstart_if.sv
// rtl/nios_system_wstart_if.sv - Avalon-MM slave bus bundle for the wstart output PIO
interface nios_system_wstart_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_wstart.sv
// rtl/nios_system_wstart.sv - output PIO with self-clearing pulse register; optional OUTSET/OUTCLR under WSTART_BITSET_EN
module nios_system_wstart #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    nios_system_wstart_if.slave  bus,
    output logic [WIDTH-1:0]     out_port
);
    localparam int CW = $clog2(PULSE_CYCLES + 1);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PULSE  = 3'd2;
`ifdef WSTART_BITSET_EN
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
`endif

    typedef enum logic {
        P_IDLE   = 1'b0,
        P_ACTIVE = 1'b1
    } pulse_state_e;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr;
    logic [WIDTH-1:0] wdata;
    pulse_state_e     pulse_state;
    logic             unused_wdata_hi;

    assign wr              = bus.chipselect & ~bus.write_n;
    assign wdata           = bus.writedata[WIDTH-1:0];
    assign unused_wdata_hi = ^bus.writedata[31:WIDTH];

    // Pulse engine state is implied by the counter: nonzero means a pulse is running
    always_comb begin
        pulse_state = (cnt_q != '0) ? P_ACTIVE : P_IDLE;
    end

    // Next-state for the data register, including optional bit set/clear aliases
    always_comb begin
        data_d = data_q;
        if (wr) begin
            case (bus.address)
                ADDR_DATA:   data_d = wdata;
`ifdef WSTART_BITSET_EN
                ADDR_OUTSET: data_d = data_q | wdata;
                ADDR_OUTCLR: data_d = data_q & ~wdata;
`endif
                default:     data_d = data_q;
            endcase
        end
    end

    // Pulse mask and countdown; a PULSE write beats a same-cycle expiry
    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        if (wr && bus.address == ADDR_PULSE) begin
            mask_d = mask_q | wdata;
            cnt_d  = CW'(PULSE_CYCLES);
        end else begin
            case (pulse_state)
                P_ACTIVE: begin
                    if (cnt_q == CW'(1)) begin
                        cnt_d  = '0;
                        mask_d = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    cnt_d  = cnt_q;
                    mask_d = mask_q;
                end
            endcase
        end
    end

    // Read mux sampled every edge regardless of chipselect, giving one-cycle read latency
    always_comb begin
        readdata_d = '0;
        case (bus.address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = data_q;
            ADDR_PULSE: begin
                readdata_d[WIDTH-1:0] = mask_q;
                readdata_d[31]        = (pulse_state == P_ACTIVE);
            end
            default: readdata_d = '0;
        endcase
    end

    // All state registers, asynchronously cleared to their reset values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = data_q | mask_q;

endmodule

// File: tb/tb_nios_system_wstart.sv
// tb/tb_nios_system_wstart.sv - directed self-checking bench for nios_system_wstart
module tb_nios_system_wstart;
    logic       clk;
    logic       reset_n;
    logic [7:0] out_port;
    int         checks;
    int         errors;

    nios_system_wstart_if bus_if ();

    nios_system_wstart #(
        .WIDTH        (8),
        .RESET_VALUE  (8'h5A),
        .PULSE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle write; returns 1ns after the sampling edge
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.address    = addr;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = data;
        @(posedge clk);
        #1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus_if.address    = 3'd1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;
        reset_n           = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out_port), 32'h5A);
        check("reset_rd", bus_if.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("release_out", 32'(out_port), 32'h5A);
        check("release_rd", bus_if.readdata, 32'h0);

        // DATA write with upper writedata bits ignored; readback latency
        bus_if.address = 3'd0;
        bus_write(3'd0, 32'hFFFF_FF3C);
        check("data_out", 32'(out_port), 32'h3C);
        check("data_rd_before", bus_if.readdata, 32'h5A);
        step();
        check("data_rd_after", bus_if.readdata, 32'h3C);

        // Single pulse, 4 cycles, busy readback
        bus_write(3'd0, 32'h0);
        bus_if.address = 3'd2;
        bus_write(3'd2, 32'h01);
        check("pulse_out_c0", 32'(out_port), 32'h01);
        check("pulse_rd_prewrite", bus_if.readdata, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("pulse_out_c%0d", i), 32'(out_port), 32'h01);
            check($sformatf("pulse_rd_c%0d", i), bus_if.readdata, 32'h8000_0001);
        end
        step();
        check("pulse_out_expired", 32'(out_port), 32'h00);
        check("pulse_rd_c4", bus_if.readdata, 32'h8000_0001);
        step();
        check("pulse_rd_idle", bus_if.readdata, 32'h0);

        // Overlapping pulses: bit0 for 6 cycles, bit1 for 4
        bus_write(3'd2, 32'h01);
        check("ovl_e0", 32'(out_port), 32'h01);
        step();
        check("ovl_e1", 32'(out_port), 32'h01);
        bus_write(3'd2, 32'h02);
        check("ovl_e2", 32'(out_port), 32'h03);
        for (int i = 3; i <= 5; i++) begin
            step();
            check($sformatf("ovl_e%0d", i), 32'(out_port), 32'h03);
        end
        step();
        check("ovl_e6", 32'(out_port), 32'h00);

        // DATA write while active; shared bit survives expiry
        bus_write(3'd2, 32'h03);
        bus_write(3'd0, 32'h01);
        check("shared_active", 32'(out_port), 32'h03);
        repeat (2) step();
        check("shared_still", 32'(out_port), 32'h03);
        step();
        check("shared_expired", 32'(out_port), 32'h01);

        // Reserved address write ignored, read returns 0
        bus_if.address = 3'd1;
        bus_write(3'd1, 32'hFF);
        check("rsvd_out", 32'(out_port), 32'h01);
        step();
        check("rsvd_rd", bus_if.readdata, 32'h0);

        // Reset in the second pulse cycle
        bus_write(3'd0, 32'h0);
        bus_write(3'd2, 32'h01);
        step();
        check("rst_pre", 32'(out_port), 32'h01);
        reset_n = 1'b0;
        #1;
        check("rst_abort", 32'(out_port), 32'h5A);
        @(negedge clk);
        reset_n        = 1'b1;
        bus_if.address = 3'd2;
        step();
        check("rst_busy", bus_if.readdata, 32'h0);
        check("rst_out", 32'(out_port), 32'h5A);

        // Bit set / clear aliases
        bus_write(3'd0, 32'hF0);
        bus_write(3'd4, 32'h0F);
`ifdef WSTART_BITSET_EN
        check("outset", 32'(out_port), 32'hFF);
`else
        check("outset", 32'(out_port), 32'hF0);
`endif
        bus_write(3'd5, 32'h81);
`ifdef WSTART_BITSET_EN
        check("outclr", 32'(out_port), 32'h7E);
`else
        check("outclr", 32'(out_port), 32'hF0);
`endif
        bus_if.address = 3'd4;
        step();
        check("outset_rd", bus_if.readdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
